// File: rtl/deadlock_report_scheduler.sv
// Deadlock report scheduler: qualifies per-monitor block flags against a
// persistence threshold and arbitrates qualified channels round-robin onto a
// single valid/ready report port, with a sticky deadlock summary flag.
module deadlock_report_scheduler #(
  parameter int unsigned NUM_MON = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic [CNT_W-1:0]   threshold_i,
  input  logic [NUM_MON-1:0] mon_block_i,
  output logic               rpt_valid_o,
  input  logic               rpt_ready_i,
  output logic [IDX_W-1:0]   rpt_idx_o,
  output logic [CNT_W-1:0]   rpt_cycles_o,
  output logic               deadlock_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MON - 1);

  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_MON];
  logic [CNT_W-1:0]   cnt_d [NUM_MON];
  logic [NUM_MON-1:0] pending_q,    pending_d;
  logic [NUM_MON-1:0] reported_q,   reported_d;
  logic [IDX_W-1:0]   rr_ptr_q,     rr_ptr_d;
  logic [IDX_W-1:0]   rpt_idx_q,    rpt_idx_d;
  logic [CNT_W-1:0]   rpt_cycles_q, rpt_cycles_d;
  logic               rpt_valid_q,  rpt_valid_d;
  logic               deadlock_q,   deadlock_d;

  logic [CNT_W-1:0]   eff_thr;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [CNT_W-1:0]   sel_cnt;

  // A zero threshold behaves as a threshold of one.
  assign eff_thr = (threshold_i == '0) ? CNT_W'(1) : threshold_i;

  // Round-robin pick: first pending channel at or above rr_ptr, else lowest pending.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_cnt   = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      if (!sel_found && pending_q[i] && (IDX_W'(i) >= rr_ptr_q)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_MON; i++) begin
      if (!sel_found && pending_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_MON; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_cnt = cnt_q[i];
      end
    end
  end

  // Next-state: report FSM, per-channel persistence counters and qualification.
  always_comb begin
    logic             accept;
    logic [CNT_W-1:0] inc;

    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    reported_d   = reported_q;
    rr_ptr_d     = rr_ptr_q;
    rpt_idx_d    = rpt_idx_q;
    rpt_cycles_d = rpt_cycles_q;
    rpt_valid_d  = rpt_valid_q;
    deadlock_d   = deadlock_q;
    accept       = 1'b0;
    inc          = '0;

    case (state_q)
      IDLE: begin
        rpt_valid_d = 1'b0;
        if (sel_found) begin
          state_d      = REPORT;
          rpt_valid_d  = 1'b1;
          rpt_idx_d    = sel_idx;
          rpt_cycles_d = sel_cnt;
        end
      end
      REPORT: begin
        rpt_valid_d = 1'b1;
        if (rpt_ready_i) begin
          accept      = 1'b1;
          state_d     = IDLE;
          rpt_valid_d = 1'b0;
          deadlock_d  = 1'b1;
          rr_ptr_d    = (rpt_idx_q == LAST_IDX) ? '0 : rpt_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        rpt_valid_d = 1'b0;
      end
    endcase

    for (int i = 0; i < NUM_MON; i++) begin
      inc = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(1);
      if (enable_i && mon_block_i[i]) begin
        cnt_d[i] = inc;
        if (!reported_q[i] && (inc == eff_thr)) begin
          pending_d[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
      // Acceptance overrides a same-cycle set so a saturated channel is not re-reported.
      if (accept && (rpt_idx_q == IDX_W'(i))) begin
        pending_d[i]  = 1'b0;
        reported_d[i] = 1'b1;
      end
      // A dropped condition re-arms the channel and wins over acceptance.
      if (enable_i && !mon_block_i[i]) begin
        pending_d[i]  = 1'b0;
        reported_d[i] = 1'b0;
      end
    end

    if (clear_i) begin
      state_d      = IDLE;
      for (int i = 0; i < NUM_MON; i++) begin
        cnt_d[i] = '0;
      end
      pending_d    = '0;
      reported_d   = '0;
      rr_ptr_d     = '0;
      rpt_idx_d    = '0;
      rpt_cycles_d = '0;
      rpt_valid_d  = 1'b0;
      deadlock_d   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      for (int i = 0; i < NUM_MON; i++) begin
        cnt_q[i] <= '0;
      end
      pending_q    <= '0;
      reported_q   <= '0;
      rr_ptr_q     <= '0;
      rpt_idx_q    <= '0;
      rpt_cycles_q <= '0;
      rpt_valid_q  <= 1'b0;
      deadlock_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      reported_q   <= reported_d;
      rr_ptr_q     <= rr_ptr_d;
      rpt_idx_q    <= rpt_idx_d;
      rpt_cycles_q <= rpt_cycles_d;
      rpt_valid_q  <= rpt_valid_d;
      deadlock_q   <= deadlock_d;
    end
  end

  assign rpt_valid_o  = rpt_valid_q;
  assign rpt_idx_o    = rpt_idx_q;
  assign rpt_cycles_o = rpt_cycles_q;
  assign deadlock_o   = deadlock_q;

endmodule

// File: tb/tb_deadlock_report_scheduler.sv
// Testbench for deadlock_report_scheduler: scenario tasks with inline checks,
// plus a scoreboard of expected reports popped on each accepted handshake.
module tb_deadlock_report_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [15:0] threshold;
  logic [3:0]  threshold4;
  logic [3:0]  mon;
  logic        ready;

  logic        valid;
  logic [1:0]  idx;
  logic [15:0] cycles;
  logic        deadlock;

  logic        valid4;
  logic [1:0]  idx4;
  logic [3:0]  cycles4;
  logic        deadlock4;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] cycles;
  } rpt_t;

  rpt_t exp_q[$];
  int   n_checks;
  int   n_fail;

  deadlock_report_scheduler #(.NUM_MON(4), .CNT_W(16), .IDX_W(2)) dut (
    .clock_i      (clk),
    .reset_i      (rst_n),
    .enable_i     (enable),
    .clear_i      (clear),
    .threshold_i  (threshold),
    .mon_block_i  (mon),
    .rpt_valid_o  (valid),
    .rpt_ready_i  (ready),
    .rpt_idx_o    (idx),
    .rpt_cycles_o (cycles),
    .deadlock_o   (deadlock)
  );

  deadlock_report_scheduler #(.NUM_MON(4), .CNT_W(4), .IDX_W(2)) dut4 (
    .clock_i      (clk),
    .reset_i      (rst_n),
    .enable_i     (enable),
    .clear_i      (clear),
    .threshold_i  (threshold4),
    .mon_block_i  (mon),
    .rpt_valid_o  (valid4),
    .rpt_ready_i  (ready),
    .rpt_idx_o    (idx4),
    .rpt_cycles_o (cycles4),
    .deadlock_o   (deadlock4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every accepted report on the main instance must match the queue head.
  always @(negedge clk) begin
    if (rst_n && !clear && valid && ready) begin
      rpt_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_report: got idx=%0d cycles=%0d, required no report", idx, cycles);
      end else begin
        e = exp_q.pop_front();
        if (idx !== e.idx || cycles !== e.cycles) begin
          n_fail++;
          $display("FAIL report_payload: got idx=%0d cycles=%0d, required idx=%0d cycles=%0d",
                   idx, cycles, e.idx, e.cycles);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", valid); end
    n_checks++;
    if (idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d, required 0", idx); end
    n_checks++;
    if (cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d, required 0", cycles); end
    n_checks++;
    if (deadlock !== 1'b0) begin n_fail++; $display("FAIL reset_deadlock: got %0b, required 0", deadlock); end
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_short_run();
    clear_pulse();
    threshold = 16'd5;
    ready     = 1'b1;
    mon       = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) mon = 4'b0000;
      tick();
      n_checks++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL short_run_valid k=%0d: got %0b, required 0", k, valid);
      end
    end
    n_checks++;
    if (deadlock !== 1'b0) begin n_fail++; $display("FAIL short_run_deadlock: got %0b, required 0", deadlock); end
  endtask

  task automatic test_single();
    clear_pulse();
    threshold = 16'd5;
    ready     = 1'b1;
    exp_q.push_back({2'd2, 16'd5});
    mon = 4'b0100;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (valid !== (k == 6)) begin
        n_fail++;
        $display("FAIL single_valid k=%0d: got %0b, required %0b", k, valid, (k == 6));
      end
      n_checks++;
      if (deadlock !== (k >= 7)) begin
        n_fail++;
        $display("FAIL single_deadlock k=%0d: got %0b, required %0b", k, deadlock, (k >= 7));
      end
    end
    mon = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    clear_pulse();
    threshold = 16'd3;
    ready     = 1'b1;
    exp_q.push_back({2'd0, 16'd3});
    exp_q.push_back({2'd1, 16'd5});
    exp_q.push_back({2'd3, 16'd7});
    mon = 4'b1011;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (valid !== (k == 4 || k == 6 || k == 8)) begin
        n_fail++;
        $display("FAIL rr_valid k=%0d: got %0b, required %0b", k, valid, (k == 4 || k == 6 || k == 8));
      end
    end
    mon = 4'b1010;
    tick();
    mon = 4'b1011;
    exp_q.push_back({2'd0, 16'd3});
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (valid !== (k == 4)) begin
        n_fail++;
        $display("FAIL rr_wrap_valid k=%0d: got %0b, required %0b", k, valid, (k == 4));
      end
      if (k == 4) begin
        n_checks++;
        if (idx !== 2'd0) begin n_fail++; $display("FAIL rr_wrap_idx: got %0d, required 0", idx); end
      end
    end
    mon = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    clear_pulse();
    threshold = 16'd2;
    ready     = 1'b0;
    mon       = 4'b0001;
    exp_q.push_back({2'd0, 16'd2});
    repeat (3) tick();
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (valid !== 1'b1 || idx !== 2'd0 || cycles !== 16'd2) begin
        n_fail++;
        $display("FAIL backpressure_hold k=%0d: got valid=%0b idx=%0d cycles=%0d, required 1/0/2",
                 k, valid, idx, cycles);
      end
      mon = (k % 2 == 0) ? 4'b0000 : 4'b0001;
      tick();
    end
    mon   = 4'b0000;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL backpressure_release: got %0b, required 0", valid); end
  endtask

  task automatic test_async_reset();
    clear_pulse();
    threshold = 16'd2;
    ready     = 1'b1;
    exp_q.push_back({2'd2, 16'd2});
    mon = 4'b0100;
    repeat (4) tick();
    n_checks++;
    if (deadlock !== 1'b1) begin n_fail++; $display("FAIL areset_pre_deadlock: got %0b, required 1", deadlock); end
    mon   = 4'b0001;
    ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %0b, required 1", valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid !== 1'b0 || deadlock !== 1'b0 || idx !== 2'd0 || cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: got valid=%0b deadlock=%0b idx=%0d cycles=%0d, required all 0",
               valid, deadlock, idx, cycles);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (valid !== (k == 3)) begin
        n_fail++;
        $display("FAIL areset_rerun_valid k=%0d: got %0b, required %0b", k, valid, (k == 3));
      end
    end
    n_checks++;
    if (cycles !== 16'd2) begin n_fail++; $display("FAIL areset_rerun_cycles: got %0d, required 2", cycles); end
    mon = 4'b0000;
    clear_pulse();
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL areset_clear_valid: got %0b, required 0", valid); end
  endtask

  task automatic test_thr_zero_saturation();
    mon = 4'b0000;
    clear_pulse();
    threshold  = 16'hFFFF;
    threshold4 = 4'd0;
    ready      = 1'b0;
    mon        = 4'b0010;
    tick();
    n_checks++;
    if (valid4 !== 1'b0) begin n_fail++; $display("FAIL thr0_first_edge: got %0b, required 0", valid4); end
    for (int k = 2; k <= 30; k++) begin
      tick();
      n_checks++;
      if (valid4 !== 1'b1 || idx4 !== 2'd1 || cycles4 !== 4'd1) begin
        n_fail++;
        $display("FAIL thr0_hold k=%0d: got valid=%0b idx=%0d cycles=%0d, required 1/1/1",
                 k, valid4, idx4, cycles4);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++;
    if (valid4 !== 1'b0 || deadlock4 !== 1'b1) begin
      n_fail++;
      $display("FAIL thr0_accept: got valid=%0b deadlock=%0b, required 0/1", valid4, deadlock4);
    end
    repeat (9) tick();
    n_checks++;
    if (valid4 !== 1'b0) begin n_fail++; $display("FAIL thr0_no_repeat: got %0b, required 0", valid4); end

    mon = 4'b0000;
    clear_pulse();
    mon = 4'b0011;
    repeat (2) tick();
    n_checks++;
    if (valid4 !== 1'b1 || idx4 !== 2'd0 || cycles4 !== 4'd1) begin
      n_fail++;
      $display("FAIL sat_first: got valid=%0b idx=%0d cycles=%0d, required 1/0/1", valid4, idx4, cycles4);
    end
    repeat (20) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    n_checks++;
    if (valid4 !== 1'b1 || idx4 !== 2'd1 || cycles4 !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_second: got valid=%0b idx=%0d cycles=%0d, required 1/1/15", valid4, idx4, cycles4);
    end
    clear_pulse();
    n_checks++;
    if (valid4 !== 1'b0 || deadlock4 !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_withdraw: got valid=%0b deadlock=%0b, required 0/0", valid4, deadlock4);
    end
    mon = 4'b0000;
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    enable     = 1'b1;
    clear      = 1'b0;
    threshold  = 16'd5;
    threshold4 = 4'd15;
    mon        = 4'b0000;
    ready      = 1'b0;

    test_reset();
    test_short_run();
    test_single();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_thr_zero_saturation();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d reports outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
